// File: rtl/noc_pck_sink.sv
// Ejection endpoint for the ProNoC traffic generator: consumes flits, returns credits,
// reassembles interleaved per-VC packets and reports latency/size/distance per packet.
module noc_pck_sink #(
  parameter int V            = 4,
  parameter int NX           = 4,
  parameter int NY           = 4,
  parameter int Fpay         = 32,
  parameter int C            = 2,
  parameter int MAX_PCK_NUM  = 10000,
  parameter int MAX_SIM_CLKs = 100000,
  parameter int MAX_PCK_SIZ  = 10,
  localparam int Xw          = (NX > 1) ? $clog2(NX) : 1,
  localparam int Yw          = (NY > 1) ? $clog2(NY) : 1,
  localparam int Cw          = (C > 1) ? $clog2(C) : 1,
  localparam int Fw          = 2 + V + Fpay,
  localparam int PCK_CNTw    = $clog2(MAX_PCK_NUM + 1),
  localparam int CLK_CNTw    = $clog2(MAX_SIM_CLKs + 1),
  localparam int PCK_SIZw    = $clog2(MAX_PCK_SIZ + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [Xw-1:0]       current_x,
  input  logic [Yw-1:0]       current_y,
  input  logic [Fw-1:0]       flit_in,
  input  logic                flit_in_wr,
  output logic [V-1:0]        credit_out,
  output logic                update,
  output logic [Xw-1:0]       src_x,
  output logic [Yw-1:0]       src_y,
  output logic [Cw-1:0]       pck_class_out,
  output logic [PCK_SIZw-1:0] pck_size_out,
  output logic [31:0]         distance,
  output logic [CLK_CNTw-1:0] time_stamp_h2h,
  output logic [CLK_CNTw-1:0] time_stamp_h2t,
  output logic [PCK_CNTw-1:0] pck_number,
  output logic [3:0]          err_flags
);

  localparam int Vw      = (V > 1) ? $clog2(V) : 1;
  localparam int DX_LSB  = 0;
  localparam int DY_LSB  = Xw;
  localparam int SX_LSB  = Xw + Yw;
  localparam int SY_LSB  = 2 * Xw + Yw;
  localparam int CL_LSB  = 2 * Xw + 2 * Yw;
  localparam int INJ_LSB = CL_LSB + Cw;
  localparam int HDRw    = INJ_LSB + CLK_CNTw;

  localparam logic [CLK_CNTw-1:0] CLK_MAX = CLK_CNTw'(MAX_SIM_CLKs);
  localparam logic [PCK_CNTw-1:0] PCK_MAX = PCK_CNTw'(MAX_PCK_NUM);
  localparam logic [PCK_SIZw-1:0] SIZ_MAX = PCK_SIZw'(MAX_PCK_SIZ);

  generate
    if (HDRw > Fpay) begin : g_cfg_check
      $fatal(1, "noc_pck_sink: header fields do not fit in Fpay");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  logic                w_hdr;
  logic                w_tail;
  logic [V-1:0]        w_vc;
  logic                w_onehot;
  logic                w_accept;
  logic [Vw-1:0]       w_vc_idx;
  logic [Xw-1:0]       w_dest_x;
  logic [Yw-1:0]       w_dest_y;
  logic [Xw-1:0]       w_src_x;
  logic [Yw-1:0]       w_src_y;
  logic [Cw-1:0]       w_class;
  logic [CLK_CNTw-1:0] w_inj;
  logic                w_dest_miss;
  logic                w_unused_payload;

  logic [CLK_CNTw-1:0] r_clk_cnt;
  logic [CLK_CNTw-1:0] w_h2h_now;

  state_t              r_state      [V];
  state_t              w_next_state [V];
  logic [Xw-1:0]       r_src_x      [V];
  logic [Yw-1:0]       r_src_y      [V];
  logic [Cw-1:0]       r_class      [V];
  logic [CLK_CNTw-1:0] r_inj        [V];
  logic [CLK_CNTw-1:0] r_h2h        [V];
  logic [PCK_SIZw-1:0] r_cnt        [V];

  logic [V-1:0]        w_load;
  logic [V-1:0]        w_incr;
  logic                w_report;
  logic                w_rep_latched;
  logic [3:0]          w_err_set;

  logic [PCK_SIZw-1:0] w_cnt_next;
  logic [Xw-1:0]       w_rep_src_x;
  logic [Yw-1:0]       w_rep_src_y;
  logic [Cw-1:0]       w_rep_class;
  logic [CLK_CNTw-1:0] w_rep_inj;
  logic [CLK_CNTw-1:0] w_rep_h2h;
  logic [CLK_CNTw-1:0] w_rep_h2t;
  logic [PCK_SIZw-1:0] w_rep_size;
  logic [Xw-1:0]       w_dx;
  logic [Yw-1:0]       w_dy;

  assign w_hdr    = flit_in[Fw-1];
  assign w_tail   = flit_in[Fw-2];
  assign w_vc     = flit_in[Fw-3:Fpay];
  assign w_onehot = $onehot(w_vc);
  assign w_accept = flit_in_wr & w_onehot;

  assign w_dest_x    = flit_in[DX_LSB +: Xw];
  assign w_dest_y    = flit_in[DY_LSB +: Yw];
  assign w_src_x     = flit_in[SX_LSB +: Xw];
  assign w_src_y     = flit_in[SY_LSB +: Yw];
  assign w_class     = flit_in[CL_LSB +: Cw];
  assign w_inj       = flit_in[INJ_LSB +: CLK_CNTw];
  assign w_dest_miss = (w_dest_x != current_x) || (w_dest_y != current_y);
  assign w_h2h_now   = r_clk_cnt - w_inj;

  generate
    if (HDRw < Fpay) begin : g_spare_bits
      assign w_unused_payload = ^flit_in[Fpay-1:HDRw];
    end else begin : g_no_spare_bits
      assign w_unused_payload = 1'b0;
    end
  endgenerate

  always_comb begin
    w_vc_idx = '0;
    for (int i = 0; i < V; i++) begin
      if (w_vc[i]) w_vc_idx = Vw'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_clk_cnt <= '0;
    end else if (r_clk_cnt != CLK_MAX) begin
      r_clk_cnt <= r_clk_cnt + CLK_CNTw'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < V; i++) r_state[i] <= IDLE;
    end else begin
      for (int i = 0; i < V; i++) r_state[i] <= w_next_state[i];
    end
  end

  // Only the VC addressed by an accepted flit can change state in a given cycle.
  always_comb begin
    for (int i = 0; i < V; i++) w_next_state[i] = r_state[i];
    w_load        = '0;
    w_incr        = '0;
    w_report      = 1'b0;
    w_rep_latched = 1'b0;
    w_err_set     = '0;
    if (flit_in_wr && !w_onehot) w_err_set[0] = 1'b1;
    if (w_accept) begin
      if (w_hdr && w_dest_miss) w_err_set[3] = 1'b1;
      case (r_state[w_vc_idx])
        IDLE: begin
          if (w_hdr && w_tail) begin
            w_report = 1'b1;
          end else if (w_hdr) begin
            w_load[w_vc_idx]       = 1'b1;
            w_next_state[w_vc_idx] = BUSY;
          end else begin
            w_err_set[1] = 1'b1;
          end
        end
        BUSY: begin
          if (w_hdr) begin
            w_err_set[2] = 1'b1;
            if (w_tail) begin
              w_report               = 1'b1;
              w_next_state[w_vc_idx] = IDLE;
            end else begin
              w_load[w_vc_idx] = 1'b1;
            end
          end else if (w_tail) begin
            w_report               = 1'b1;
            w_rep_latched          = 1'b1;
            w_next_state[w_vc_idx] = IDLE;
          end else begin
            w_incr[w_vc_idx] = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // A report either comes from the per-VC latch (multi-flit) or straight from the header flit.
  always_comb begin
    w_cnt_next  = (r_cnt[w_vc_idx] >= SIZ_MAX) ? SIZ_MAX : r_cnt[w_vc_idx] + PCK_SIZw'(1);
    w_rep_src_x = w_rep_latched ? r_src_x[w_vc_idx] : w_src_x;
    w_rep_src_y = w_rep_latched ? r_src_y[w_vc_idx] : w_src_y;
    w_rep_class = w_rep_latched ? r_class[w_vc_idx] : w_class;
    w_rep_inj   = w_rep_latched ? r_inj[w_vc_idx]   : w_inj;
    w_rep_h2h   = w_rep_latched ? r_h2h[w_vc_idx]   : w_h2h_now;
    w_rep_size  = w_rep_latched ? w_cnt_next        : PCK_SIZw'(1);
    w_rep_h2t   = r_clk_cnt - w_rep_inj;
    w_dx        = (w_rep_src_x >= current_x) ? w_rep_src_x - current_x : current_x - w_rep_src_x;
    w_dy        = (w_rep_src_y >= current_y) ? w_rep_src_y - current_y : current_y - w_rep_src_y;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < V; i++) begin
        r_src_x[i] <= '0;
        r_src_y[i] <= '0;
        r_class[i] <= '0;
        r_inj[i]   <= '0;
        r_h2h[i]   <= '0;
        r_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < V; i++) begin
        if (w_load[i]) begin
          r_src_x[i] <= w_src_x;
          r_src_y[i] <= w_src_y;
          r_class[i] <= w_class;
          r_inj[i]   <= w_inj;
          r_h2h[i]   <= w_h2h_now;
          r_cnt[i]   <= PCK_SIZw'(1);
        end else if (w_incr[i]) begin
          r_cnt[i] <= w_cnt_next;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      credit_out     <= '0;
      update         <= 1'b0;
      src_x          <= '0;
      src_y          <= '0;
      pck_class_out  <= '0;
      pck_size_out   <= '0;
      distance       <= '0;
      time_stamp_h2h <= '0;
      time_stamp_h2t <= '0;
      pck_number     <= '0;
      err_flags      <= '0;
    end else begin
      credit_out <= w_accept ? w_vc : '0;
      update     <= w_report;
      err_flags  <= err_flags | w_err_set;
      if (w_report) begin
        src_x          <= w_rep_src_x;
        src_y          <= w_rep_src_y;
        pck_class_out  <= w_rep_class;
        pck_size_out   <= w_rep_size;
        distance       <= 32'(w_dx) + 32'(w_dy);
        time_stamp_h2h <= w_rep_h2h;
        time_stamp_h2t <= w_rep_h2t;
        if (pck_number != PCK_MAX) pck_number <= pck_number + PCK_CNTw'(1);
      end
    end
  end

endmodule

// File: tb/tb_noc_pck_sink.sv
// Randomized and directed checks of noc_pck_sink against a packet-level reference model
// that tracks open packets per VC and derives each report from header/tail arrival times.
module tb_noc_pck_sink;
  localparam int Fw           = 38;
  localparam int MAX_PCK_NUM  = 10000;
  localparam int MAX_SIM_CLKs = 100000;
  localparam int MAX_PCK_SIZ  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  current_x, current_y;
  logic [Fw-1:0] flit_in;
  logic        flit_in_wr;
  logic [3:0]  credit_out;
  logic        update;
  logic [1:0]  src_x, src_y;
  logic [0:0]  pck_class_out;
  logic [3:0]  pck_size_out;
  logic [31:0] distance;
  logic [16:0] time_stamp_h2h, time_stamp_h2t;
  logic [13:0] pck_number;
  logic [3:0]  err_flags;

  noc_pck_sink dut (
    .clk(clk), .reset(reset), .current_x(current_x), .current_y(current_y),
    .flit_in(flit_in), .flit_in_wr(flit_in_wr), .credit_out(credit_out), .update(update),
    .src_x(src_x), .src_y(src_y), .pck_class_out(pck_class_out), .pck_size_out(pck_size_out),
    .distance(distance), .time_stamp_h2h(time_stamp_h2h), .time_stamp_h2t(time_stamp_h2t),
    .pck_number(pck_number), .err_flags(err_flags)
  );

  always #5 clk = ~clk;

  int nCompared = 0;
  int nMismatched = 0;
  bit checkEn = 1'b0;
  int credit2Cnt = 0;
  int updCnt = 0;

  // Reference model: open packet per VC plus expected outputs after the next edge
  bit   mOpen [4];
  int   mSx [4], mSy [4], mCls [4], mInj [4], mHdrT [4], mFlits [4];
  int   mClk = 0;
  logic [3:0] eCredit = '0;
  logic       eUpdate = 1'b0;
  logic [3:0] eErr = '0;
  int eSx = 0, eSy = 0, eCls = 0, eSize = 0, eDist = 0, eH2h = 0, eH2t = 0, ePck = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s at %0t: actual=%0d required=%0d", name, $time, actual, expected);
    end
  endtask

  function automatic int absI(input int a);
    return (a < 0) ? -a : a;
  endfunction

  task automatic reportPkt(input int v, input int arrival);
    logic [16:0] d;
    eUpdate = 1'b1;
    eSx  = mSx[v];
    eSy  = mSy[v];
    eCls = mCls[v];
    eSize = (mFlits[v] > MAX_PCK_SIZ) ? MAX_PCK_SIZ : mFlits[v];
    d = 17'(mHdrT[v] - mInj[v]);
    eH2h = int'(d);
    d = 17'(arrival - mInj[v]);
    eH2t = int'(d);
    eDist = absI(mSx[v] - int'(current_x)) + absI(mSy[v] - int'(current_y));
    if (ePck < MAX_PCK_NUM) ePck++;
    mOpen[v] = 1'b0;
  endtask

  task automatic modelStep(input logic rst, input logic wr, input logic [Fw-1:0] f);
    logic [31:0] p;
    logic [3:0]  vc;
    int v, arr;
    p = f[31:0];
    vc = f[35:32];
    eCredit = '0;
    eUpdate = 1'b0;
    if (!rst) begin
      for (int i = 0; i < 4; i++) mOpen[i] = 1'b0;
      eSx = 0; eSy = 0; eCls = 0; eSize = 0; eDist = 0; eH2h = 0; eH2t = 0; ePck = 0;
      eErr = '0;
    end else if (wr) begin
      if ($countones(vc) != 1) begin
        eErr[0] = 1'b1;
      end else begin
        v = 0;
        for (int i = 0; i < 4; i++) if (vc[i]) v = i;
        arr = mClk;
        eCredit = vc;
        if (f[37] && (p[1:0] != current_x || p[3:2] != current_y)) eErr[3] = 1'b1;
        if (f[37]) begin
          if (mOpen[v]) eErr[2] = 1'b1;
          mOpen[v] = 1'b1;
          mSx[v] = int'(p[5:4]);
          mSy[v] = int'(p[7:6]);
          mCls[v] = int'(p[8]);
          mInj[v] = int'(p[25:9]);
          mHdrT[v] = arr;
          mFlits[v] = 1;
        end else if (!mOpen[v]) begin
          eErr[1] = 1'b1;
        end else begin
          mFlits[v]++;
        end
        if (mOpen[v] && f[36]) reportPkt(v, arr);
      end
    end
    if (!rst) mClk = 0;
    else if (mClk < MAX_SIM_CLKs) mClk++;
  endtask

  function automatic logic [Fw-1:0] mkFlit(input logic hdr, input logic tail, input logic [3:0] vc,
                                            input logic [31:0] pay);
    return {hdr, tail, vc, pay};
  endfunction

  function automatic logic [31:0] mkHdr(input logic [1:0] dx, input logic [1:0] dy, input logic [1:0] sx,
                                         input logic [1:0] sy, input logic cls, input logic [16:0] inj);
    logic [31:0] p;
    p = $urandom;
    p[1:0] = dx;
    p[3:2] = dy;
    p[5:4] = sx;
    p[7:6] = sy;
    p[8] = cls;
    p[25:9] = inj;
    return p;
  endfunction

  function automatic logic [Fw-1:0] randFlit();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[Fw-1:0];
  endfunction

  task automatic applyStimulus(input logic rst, input logic wr, input logic [Fw-1:0] f);
    @(negedge clk);
    #2;
    reset = rst;
    flit_in_wr = wr;
    flit_in = f;
    modelStep(rst, wr, f);
  endtask

  task automatic sendFlit(input logic hdr, input logic tail, input logic [3:0] vc, input logic [31:0] pay);
    applyStimulus(1'b1, 1'b1, mkFlit(hdr, tail, vc, pay));
  endtask

  task automatic idle();
    applyStimulus(1'b1, 1'b0, randFlit());
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, randFlit());
  endtask

  task automatic idleUntil(input int t);
    for (int k = 0; k < 200 && mClk != t; k++) idle();
  endtask

  // Per-cycle comparison of every output against the model
  initial forever begin
    @(negedge clk);
    if (checkEn) begin
      checkOutput("credit_out", 32'(credit_out), 32'(eCredit));
      checkOutput("update", 32'(update), 32'(eUpdate));
      checkOutput("err_flags", 32'(err_flags), 32'(eErr));
      checkOutput("pck_number", 32'(pck_number), 32'(ePck));
      checkOutput("src_x", 32'(src_x), 32'(eSx));
      checkOutput("src_y", 32'(src_y), 32'(eSy));
      checkOutput("pck_class", 32'(pck_class_out), 32'(eCls));
      checkOutput("pck_size", 32'(pck_size_out), 32'(eSize));
      checkOutput("distance", distance, 32'(eDist));
      checkOutput("h2h", 32'(time_stamp_h2h), 32'(eH2h));
      checkOutput("h2t", 32'(time_stamp_h2t), 32'(eH2t));
    end
  end

  initial forever begin
    @(negedge clk);
    if (credit_out[2]) credit2Cnt++;
    if (update) updCnt++;
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c2Start, updStart;
    logic [3:0] vc;
    reset = 1'b0;
    flit_in_wr = 1'b0;
    flit_in = '0;
    current_x = 2'd0;
    current_y = 2'd0;

    doReset();
    checkEn = 1'b1;
    idle();
    checkOutput("reset_pck_number", 32'(pck_number), 32'd0);
    checkOutput("reset_err_flags", 32'(err_flags), 32'd0);

    // Single-flit packet on VC0, arrival at 12, injection at 5
    doReset();
    idleUntil(12);
    sendFlit(1'b1, 1'b1, 4'b0001, mkHdr(2'd0, 2'd0, 2'd1, 2'd2, 1'b0, 17'd5));
    idle();
    checkOutput("t1_credit", 32'(credit_out), 32'h1);
    checkOutput("t1_update", 32'(update), 32'd1);
    checkOutput("t1_h2h", 32'(time_stamp_h2h), 32'd7);
    checkOutput("t1_h2t", 32'(time_stamp_h2t), 32'd7);
    checkOutput("t1_distance", distance, 32'd3);
    checkOutput("t1_size", 32'(pck_size_out), 32'd1);

    // Four-flit packet on VC2, header at 20 and tail at 30
    doReset();
    c2Start = credit2Cnt;
    idleUntil(20);
    sendFlit(1'b1, 1'b0, 4'b0100, mkHdr(2'd0, 2'd0, 2'd3, 2'd3, 1'b1, 17'd10));
    idleUntil(24);
    sendFlit(1'b0, 1'b0, 4'b0100, $urandom);
    idleUntil(27);
    sendFlit(1'b0, 1'b0, 4'b0100, $urandom);
    idleUntil(30);
    sendFlit(1'b0, 1'b1, 4'b0100, $urandom);
    idle();
    checkOutput("t2_h2h", 32'(time_stamp_h2h), 32'd10);
    checkOutput("t2_h2t", 32'(time_stamp_h2t), 32'd20);
    checkOutput("t2_size", 32'(pck_size_out), 32'd4);
    checkOutput("t2_credits", 32'(credit2Cnt - c2Start), 32'd4);

    // Interleaved packets on VC0 and VC1
    doReset();
    sendFlit(1'b1, 1'b0, 4'b0001, mkHdr(2'd0, 2'd0, 2'd3, 2'd1, 1'b0, 17'd0));
    sendFlit(1'b1, 1'b0, 4'b0010, mkHdr(2'd0, 2'd0, 2'd2, 2'd3, 1'b1, 17'd0));
    sendFlit(1'b0, 1'b0, 4'b0001, $urandom);
    sendFlit(1'b0, 1'b1, 4'b0010, $urandom);
    sendFlit(1'b0, 1'b1, 4'b0001, $urandom);
    checkOutput("t3_vc1_src_x", 32'(src_x), 32'd2);
    checkOutput("t3_vc1_src_y", 32'(src_y), 32'd3);
    checkOutput("t3_vc1_size", 32'(pck_size_out), 32'd2);
    idle();
    checkOutput("t3_vc0_src_x", 32'(src_x), 32'd3);
    checkOutput("t3_vc0_src_y", 32'(src_y), 32'd1);
    checkOutput("t3_vc0_size", 32'(pck_size_out), 32'd3);
    checkOutput("t3_pck_number", 32'(pck_number), 32'd2);

    // Protocol errors
    doReset();
    sendFlit(1'b0, 1'b0, 4'b1000, $urandom);
    sendFlit(1'b1, 1'b0, 4'b0010, mkHdr(2'd0, 2'd0, 2'd1, 2'd1, 1'b0, 17'd0));
    sendFlit(1'b1, 1'b0, 4'b0010, mkHdr(2'd0, 2'd0, 2'd1, 2'd1, 1'b0, 17'd0));
    sendFlit(1'b1, 1'b0, 4'b0011, mkHdr(2'd0, 2'd0, 2'd1, 2'd1, 1'b0, 17'd0));
    idle();
    checkOutput("t4_err_flags", 32'(err_flags), 32'h7);
    checkOutput("t4_no_credit", 32'(credit_out), 32'h0);
    sendFlit(1'b1, 1'b0, 4'b0100, mkHdr(2'd1, 2'd1, 2'd1, 2'd1, 1'b0, 17'd0));
    idle();
    checkOutput("t4_dest_err", 32'(err_flags), 32'hF);

    // Reset in the middle of a VC2 packet
    doReset();
    sendFlit(1'b1, 1'b0, 4'b0100, mkHdr(2'd0, 2'd0, 2'd2, 2'd2, 1'b0, 17'd0));
    sendFlit(1'b0, 1'b0, 4'b0100, $urandom);
    doReset();
    sendFlit(1'b0, 1'b1, 4'b0100, $urandom);
    idle();
    checkOutput("t5_err_flags", 32'(err_flags), 32'h2);
    checkOutput("t5_update", 32'(update), 32'd0);
    checkOutput("t5_pck_number", 32'(pck_number), 32'd0);

    // Packet longer than the size counter limit
    doReset();
    sendFlit(1'b1, 1'b0, 4'b0001, mkHdr(2'd0, 2'd0, 2'd1, 2'd0, 1'b0, 17'd0));
    for (int i = 0; i < 10; i++) sendFlit(1'b0, 1'b0, 4'b0001, $urandom);
    sendFlit(1'b0, 1'b1, 4'b0001, $urandom);
    idle();
    checkOutput("size_saturation", 32'(pck_size_out), 32'd10);

    // Packet counter saturation
    doReset();
    updStart = updCnt;
    for (int i = 0; i < MAX_PCK_NUM + 2; i++) begin
      vc = 4'b0001 << $urandom_range(0, 3);
      sendFlit(1'b1, 1'b1, vc, mkHdr(2'd0, 2'd0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                                     1'($urandom_range(0, 1)), 17'($urandom)));
    end
    idle();
    checkOutput("t6_pck_number", 32'(pck_number), 32'(MAX_PCK_NUM));
    checkOutput("t6_update_count", 32'(updCnt - updStart), 32'(MAX_PCK_NUM + 2));

    // Randomized traffic against the model
    current_x = 2'd2;
    current_y = 2'd1;
    doReset();
    for (int n = 0; n < 4000; n++) begin
      int r, v;
      logic hdr, tail;
      logic [1:0] dx, dy;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        doReset();
      end else if (r < 25) begin
        idle();
      end else begin
        v = $urandom_range(0, 3);
        vc = 4'b0001 << v;
        if ($urandom_range(0, 19) == 0) vc = 4'($urandom);
        hdr = mOpen[v] ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 19) != 0);
        tail = ($urandom_range(0, 9) < 3);
        dx = current_x;
        dy = current_y;
        if ($urandom_range(0, 9) == 0) begin
          dx = 2'($urandom);
          dy = 2'($urandom);
        end
        if (hdr)
          sendFlit(hdr, tail, vc, mkHdr(dx, dy, 2'($urandom), 2'($urandom), 1'($urandom), 17'($urandom)));
        else
          sendFlit(hdr, tail, vc, $urandom);
      end
    end
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
